// File: rtl/qint_multi_pkg.sv
// Shared constants for the multi-channel QBUS interrupt requester:
// priority level codes, FSM state encodings and an index-width helper.
package qint_multi_pkg;

  localparam logic [1:0] INTP_4 = 2'd0;
  localparam logic [1:0] INTP_5 = 2'd1;
  localparam logic [1:0] INTP_6 = 2'd2;
  localparam logic [1:0] INTP_7 = 2'd3;

  localparam logic [1:0] QI_IDLE   = 2'd0;
  localparam logic [1:0] QI_ARMED  = 2'd1;
  localparam logic [1:0] QI_VECTOR = 2'd2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/qint_arbiter.sv
// Combinational priority encoder: highest level among pending channels,
// ties resolved toward the lowest channel index.
module qint_arbiter
  import qint_multi_pkg::*;
#(
  parameter int NCHAN = 4,
  localparam int IW = idx_w(NCHAN)
) (
  input  logic [NCHAN-1:0]   pending,
  input  logic [2*NCHAN-1:0] int_priority,
  output logic               valid,
  output logic [IW-1:0]      idx,
  output logic [1:0]         level
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    level = INTP_4;
    // strict '>' keeps the earlier (lower) index on equal levels
    for (int i = 0; i < NCHAN; i++) begin
      if (pending[i] && (!valid || int_priority[2*i +: 2] > level)) begin
        valid = 1'b1;
        idx   = IW'(i);
        level = int_priority[2*i +: 2];
      end
    end
  end

endmodule

// File: rtl/qint_multi.sv
// QBUS interrupt requester: NCHAN sources share one IRQ/IAK daisy-chain slot.
// Pending tracking, IRQ line drive, DIN/IAK handshake FSM and vector output.
module qint_multi
  import qint_multi_pkg::*;
#(
  parameter int NCHAN   = 4,
  parameter bit LATCHED = 1'b1,
  localparam int IW = idx_w(NCHAN)
) (
  input  logic               clk,
  input  logic               RINIT,
  input  logic [2*NCHAN-1:0] int_priority,
  input  logic [7*NCHAN-1:0] int_vector,
  input  logic [NCHAN-1:0]   interrupt_request,
  input  logic [NCHAN-1:0]   irq_cancel,
  input  logic               RDIN,
  input  logic [4:7]         RIRQ,
  input  logic               RIAKI,
  output logic [4:7]         TIRQ,
  output logic               TIAKO,
  output logic               assert_vector,
  output logic [15:0]        vector_out,
  output logic [NCHAN-1:0]   int_ack
);

  logic [NCHAN-1:0] req_q, req_d, pending_q, pending_d, ack_q, ack_d, svc;
  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    win_idx_q, win_idx_d;
  logic [6:0]       win_vec_q, win_vec_d;
  logic [4:7]       tirq_q, tirq_d;
  logic             rdin_q, rdin_d;

  logic             arb_valid, irq_higher, din_edge;
  logic [IW-1:0]    arb_idx;
  logic [1:0]       arb_level;
  logic [6:0]       vec_arr [NCHAN];
  logic             unused_rirq4;

  assign unused_rirq4 = RIRQ[4];

  qint_arbiter #(.NCHAN(NCHAN)) u_arb (
    .pending      (pending_q),
    .int_priority (int_priority),
    .valid        (arb_valid),
    .idx          (arb_idx),
    .level        (arb_level)
  );

  always_comb begin
    for (int i = 0; i < NCHAN; i++) vec_arr[i] = int_vector[7*i +: 7];
  end

  always_comb begin
    case (arb_level)
      INTP_4:  irq_higher = RIRQ[5] | RIRQ[6];
      INTP_5:  irq_higher = RIRQ[6];
      INTP_6:  irq_higher = RIRQ[7];
      default: irq_higher = 1'b0;
    endcase
  end

  assign din_edge = RDIN & ~rdin_q;
  assign req_d    = interrupt_request;
  assign rdin_d   = RDIN;

  // cancel beats a new request edge, which beats the acknowledge clear
  always_comb begin
    for (int i = 0; i < NCHAN; i++) begin
      if (!LATCHED)                                  pending_d[i] = interrupt_request[i];
      else if (irq_cancel[i])                        pending_d[i] = 1'b0;
      else if (interrupt_request[i] && !req_q[i])    pending_d[i] = 1'b1;
      else if (ack_q[i])                             pending_d[i] = 1'b0;
      else                                           pending_d[i] = pending_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    win_idx_d = win_idx_q;
    win_vec_d = win_vec_q;
    ack_d     = '0;
    case (state_q)
      QI_IDLE: begin
        if (din_edge && arb_valid && !irq_higher) begin
          state_d   = QI_ARMED;
          win_idx_d = arb_idx;
          win_vec_d = vec_arr[arb_idx];
        end
      end
      QI_ARMED: begin
        if (irq_cancel[win_idx_q] || !pending_q[win_idx_q]) begin
          state_d = QI_IDLE;
        end else if (RIAKI) begin
          state_d          = QI_VECTOR;
          ack_d[win_idx_q] = 1'b1;
        end else if (din_edge) begin
          if (arb_valid && !irq_higher) begin
            win_idx_d = arb_idx;
            win_vec_d = vec_arr[arb_idx];
          end else begin
            state_d = QI_IDLE;
          end
        end
      end
      QI_VECTOR: begin
        if (!RIAKI || !RDIN) state_d = QI_IDLE;
      end
      default: state_d = QI_IDLE;
    endcase
  end

  // the channel being vectored stops driving its IRQ lines
  always_comb begin
    svc    = '0;
    tirq_d = '0;
    if (state_q == QI_VECTOR) svc[win_idx_q] = 1'b1;
    for (int i = 0; i < NCHAN; i++) begin
      if (pending_q[i] && !svc[i]) begin
        tirq_d[4] = 1'b1;
        case (int_priority[2*i +: 2])
          INTP_5:  tirq_d[5] = 1'b1;
          INTP_6:  tirq_d[6] = 1'b1;
          INTP_7:  begin tirq_d[6] = 1'b1; tirq_d[7] = 1'b1; end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    req_q  <= req_d;
    rdin_q <= rdin_d;
    if (RINIT) begin
      pending_q <= '0;
      state_q   <= QI_IDLE;
      win_idx_q <= '0;
      win_vec_q <= '0;
      tirq_q    <= '0;
      ack_q     <= '0;
    end else begin
      pending_q <= pending_d;
      state_q   <= state_d;
      win_idx_q <= win_idx_d;
      win_vec_q <= win_vec_d;
      tirq_q    <= tirq_d;
      ack_q     <= ack_d;
    end
  end

  assign TIRQ          = tirq_q;
  assign TIAKO         = RIAKI & ~(state_q == QI_ARMED || state_q == QI_VECTOR);
  assign assert_vector = (state_q == QI_VECTOR);
  assign vector_out    = assert_vector ? {7'b0, win_vec_q, 2'b00} : 16'h0000;
  assign int_ack       = ack_q;

endmodule

// File: tb/tb_qint_multi.sv
// Directed bench for qint_multi: one task per scenario, inline checks.
module tb_qint_multi;
  logic        clk = 1'b0;
  logic        RINIT;
  logic [7:0]  int_priority;
  logic [27:0] int_vector;
  logic [3:0]  interrupt_request, irq_cancel;
  logic        RDIN, RIAKI;
  logic [4:7]  RIRQ;
  logic [4:7]  TIRQ;
  logic        TIAKO, assert_vector;
  logic [15:0] vector_out;
  logic [3:0]  int_ack;
  int n_run = 0, n_fail = 0;

  always #5 clk = ~clk;

  qint_multi #(.NCHAN(4), .LATCHED(1'b1)) dut (
    .clk(clk), .RINIT(RINIT), .int_priority(int_priority), .int_vector(int_vector),
    .interrupt_request(interrupt_request), .irq_cancel(irq_cancel), .RDIN(RDIN),
    .RIRQ(RIRQ), .RIAKI(RIAKI), .TIRQ(TIRQ), .TIAKO(TIAKO),
    .assert_vector(assert_vector), .vector_out(vector_out), .int_ack(int_ack)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic arm_and_iak();
    RDIN = 1'b1; tick();
    RIAKI = 1'b1; tick();
  endtask

  task automatic release_bus();
    RDIN = 1'b0; RIAKI = 1'b0; tick();
  endtask

  task automatic test_reset();
    RINIT = 1'b1; int_priority = '0; int_vector = '0; interrupt_request = '0;
    irq_cancel = '0; RDIN = 1'b0; RIAKI = 1'b0; RIRQ = '0;
    tick(); tick();
    n_run++; if (TIRQ !== 4'b0000) begin n_fail++; $display("FAIL rst_tirq: got %b want 0000", TIRQ); end
    n_run++; if (assert_vector !== 1'b0 || vector_out !== 16'h0) begin n_fail++; $display("FAIL rst_vec: got %b/%h want 0/0000", assert_vector, vector_out); end
    n_run++; if (int_ack !== 4'b0000) begin n_fail++; $display("FAIL rst_ack: got %b want 0000", int_ack); end
    RIAKI = 1'b1; #1;
    n_run++; if (TIAKO !== 1'b1) begin n_fail++; $display("FAIL rst_tiako: got %b want 1", TIAKO); end
    RIAKI = 1'b0; RINIT = 1'b0; tick();
  endtask

  task automatic test_single();
    int_priority[5:4] = 2'd1; int_vector[20:14] = 7'o61;
    interrupt_request[2] = 1'b1; tick(); tick();
    n_run++; if (TIRQ !== 4'b1100) begin n_fail++; $display("FAIL t1_tirq: got %b want 1100", TIRQ); end
    RDIN = 1'b1; tick();
    RIAKI = 1'b1; #1;
    n_run++; if (TIAKO !== 1'b0) begin n_fail++; $display("FAIL t1_tiako: got %b want 0", TIAKO); end
    tick();
    n_run++; if (assert_vector !== 1'b1) begin n_fail++; $display("FAIL t1_av: got %b want 1", assert_vector); end
    n_run++; if (vector_out !== 16'o304) begin n_fail++; $display("FAIL t1_vec: got %o want 304", vector_out); end
    n_run++; if (int_ack !== 4'b0100) begin n_fail++; $display("FAIL t1_ack: got %b want 0100", int_ack); end
    tick();
    n_run++; if (int_ack !== 4'b0000) begin n_fail++; $display("FAIL t1_ack_pulse: got %b want 0000", int_ack); end
    n_run++; if (TIRQ !== 4'b0000) begin n_fail++; $display("FAIL t1_tirq_drop: got %b want 0000", TIRQ); end
    interrupt_request = '0; release_bus();
    n_run++; if (assert_vector !== 1'b0 || vector_out !== 16'h0) begin n_fail++; $display("FAIL t1_idle: got %b/%o want 0/0", assert_vector, vector_out); end
  endtask

  task automatic test_priority();
    int_priority = {2'd2, 2'd0, 2'd0, 2'd0};
    int_vector[6:0] = 7'o10; int_vector[27:21] = 7'o20;
    interrupt_request = 4'b1001; tick(); tick();
    n_run++; if (TIRQ !== 4'b1010) begin n_fail++; $display("FAIL t2_tirq: got %b want 1010", TIRQ); end
    arm_and_iak();
    n_run++; if (vector_out !== 16'o100 || int_ack !== 4'b1000) begin n_fail++; $display("FAIL t2_first: got %o/%b want 100/1000", vector_out, int_ack); end
    release_bus();
    n_run++; if (TIRQ !== 4'b1000) begin n_fail++; $display("FAIL t2_tirq_rem: got %b want 1000", TIRQ); end
    arm_and_iak();
    n_run++; if (vector_out !== 16'o40 || int_ack !== 4'b0001) begin n_fail++; $display("FAIL t2_second: got %o/%b want 40/0001", vector_out, int_ack); end
    interrupt_request = '0; release_bus(); tick();
  endtask

  task automatic test_higher_blocks();
    int_priority = {2'd0, 2'd0, 2'd0, 2'd0};
    RIRQ = 4'b0010; interrupt_request[1] = 1'b1; tick(); tick();
    RDIN = 1'b1; tick();
    RIAKI = 1'b1; #1;
    n_run++; if (TIAKO !== 1'b1) begin n_fail++; $display("FAIL t3_tiako: got %b want 1", TIAKO); end
    tick();
    n_run++; if (assert_vector !== 1'b0) begin n_fail++; $display("FAIL t3_av: got %b want 0", assert_vector); end
    release_bus(); RIRQ = '0;
    irq_cancel[1] = 1'b1; interrupt_request = '0; tick();
    irq_cancel = '0; tick();
    n_run++; if (TIRQ !== 4'b0000) begin n_fail++; $display("FAIL t3_cancel: got %b want 0000", TIRQ); end
  endtask

  task automatic test_tie();
    int_priority = {2'd0, 2'd0, 2'd3, 2'd3};
    int_vector[6:0] = 7'o30; int_vector[13:7] = 7'o31;
    interrupt_request = 4'b0011; tick(); tick();
    n_run++; if (TIRQ !== 4'b1011) begin n_fail++; $display("FAIL t4_tirq: got %b want 1011", TIRQ); end
    arm_and_iak();
    n_run++; if (vector_out !== 16'o140 || int_ack !== 4'b0001) begin n_fail++; $display("FAIL t4_first: got %o/%b want 140/0001", vector_out, int_ack); end
    RIAKI = 1'b0; tick();
    n_run++; if (assert_vector !== 1'b0) begin n_fail++; $display("FAIL t4_iak_drop: got %b want 0", assert_vector); end
    RDIN = 1'b0; tick();
    arm_and_iak();
    n_run++; if (vector_out !== 16'o144 || int_ack !== 4'b0010) begin n_fail++; $display("FAIL t4_second: got %o/%b want 144/0010", vector_out, int_ack); end
    interrupt_request = '0; release_bus(); tick();
  endtask

  task automatic test_cancel();
    int_priority = {2'd0, 2'd1, 2'd0, 2'd0}; int_vector[20:14] = 7'o61;
    interrupt_request[2] = 1'b1; tick(); tick();
    RDIN = 1'b1; tick();
    irq_cancel[2] = 1'b1; tick();
    irq_cancel = '0; tick();
    n_run++; if (TIRQ !== 4'b0000) begin n_fail++; $display("FAIL t5_tirq: got %b want 0000", TIRQ); end
    RIAKI = 1'b1; #1;
    n_run++; if (TIAKO !== 1'b1) begin n_fail++; $display("FAIL t5_tiako: got %b want 1", TIAKO); end
    tick();
    n_run++; if (assert_vector !== 1'b0) begin n_fail++; $display("FAIL t5_av: got %b want 0", assert_vector); end
    interrupt_request = '0; release_bus();
  endtask

  task automatic test_reset_in_vector();
    int_priority = {2'd0, 2'd0, 2'd2, 2'd0}; int_vector[13:7] = 7'o40;
    interrupt_request = 4'b1010; tick(); tick();
    arm_and_iak();
    n_run++; if (assert_vector !== 1'b1 || vector_out !== 16'o200) begin n_fail++; $display("FAIL t6_vec: got %b/%o want 1/200", assert_vector, vector_out); end
    RINIT = 1'b1; tick();
    n_run++; if (assert_vector !== 1'b0 || vector_out !== 16'h0) begin n_fail++; $display("FAIL t6_av: got %b/%o want 0/0", assert_vector, vector_out); end
    n_run++; if (int_ack !== 4'b0000 || TIRQ !== 4'b0000) begin n_fail++; $display("FAIL t6_ack_tirq: got %b/%b want 0000/0000", int_ack, TIRQ); end
    RINIT = 1'b0; RDIN = 1'b0; RIAKI = 1'b0; tick(); tick();
    n_run++; if (TIRQ !== 4'b0000) begin n_fail++; $display("FAIL t6_pending: got %b want 0000", TIRQ); end
    interrupt_request = '0; tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_higher_blocks();
    test_tie();
    test_cancel();
    test_reset_in_vector();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
